// File: rtl/uart_boot_pkg.sv
// Shared types and constants for the UART firmware boot loader.
// The CSUM state is only reachable when UART_BOOT_LOADER_CHECKSUM_EN is defined.
package uart_boot_pkg;

    typedef enum logic [2:0] {
        WAIT_MAGIC,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERROR
    } boot_state_e;

    localparam logic [7:0] BOOT_MAGIC = 8'hA5;
    localparam int         LEN_W      = 16;

endpackage

// File: rtl/boot_word_packer.sv
// Packs a byte stream into DATA_WIDTH words in either byte order.
// word_o/word_valid_o present the completed word in the cycle of its last byte.
module boot_word_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int BIG_ENDIAN = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_i,
    output logic [DATA_WIDTH-1:0] word_o,
    output logic                  word_valid_o
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LW    = $clog2(BYTES);

    logic [LW-1:0]         lane_q, lane_d;
    logic [LW-1:0]         pos;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;

    always_comb begin
        acc_d        = acc_q;
        lane_d       = lane_q;
        word_valid_o = 1'b0;
        pos          = (BIG_ENDIAN != 0) ? (LW'(BYTES - 1) - lane_q) : lane_q;
        if (clr_i) begin
            acc_d  = '0;
            lane_d = '0;
        end else if (byte_valid_i) begin
            acc_d[{pos, 3'b000} +: 8] = byte_i;
            // BYTES is a power of two, so the lane counter wraps on its own
            lane_d       = lane_q + 1'b1;
            word_valid_o = (lane_q == LW'(BYTES - 1));
        end
    end

    assign word_o = acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            lane_q <= '0;
        end else begin
            acc_q  <= acc_d;
            lane_q <= lane_d;
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: parses A5/len/payload frames, writes RAM, releases core reset.
// Optional trailing checksum byte is enabled by defining UART_BOOT_LOADER_CHECKSUM_EN.
module uart_boot_loader
    import uart_boot_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int LOAD_BASE      = 0,
    parameter int MAX_WORDS      = 4096,
    parameter int BIG_ENDIAN     = 0,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_valid_i,
    input  logic [7:0]            rx_data_i,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic                  core_rst_n_o,
    output logic                  done_o,
    output logic                  error_o
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(LOAD_BASE);

    boot_state_e           state_q, state_d;
    logic [LEN_W-1:0]      n_q, n_d;
    logic [LEN_W-1:0]      words_q, words_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           idle_q, idle_d;
    logic                  mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  core_rst_n_q, core_rst_n_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
    logic [7:0]            sum_q, sum_d;
`endif

    logic                  active;
    logic                  timeout;
    logic                  pk_valid;
    logic [DATA_WIDTH-1:0] pk_word;
    logic [LEN_W-1:0]      len_w;
    logic [63:0]           end_addr;
    logic                  too_big;

    assign active   = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                      (state_q == DATA)   || (state_q == CSUM);
    assign timeout  = (TIMEOUT_CYCLES != 0) && active && !rx_valid_i &&
                      ((idle_q + 32'd1) == 32'(TIMEOUT_CYCLES));

    boot_word_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (timeout),
        .byte_valid_i (rx_valid_i && (state_q == DATA)),
        .byte_i       (rx_data_i),
        .word_o       (pk_word),
        .word_valid_o (pk_valid)
    );

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        words_d      = words_q;
        addr_d       = addr_q;
        mem_we_d     = 1'b0;
        wdata_d      = wdata_q;
        core_rst_n_d = core_rst_n_q;
        done_d       = done_q;
        error_d      = error_q;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
        sum_d        = sum_q;
`endif
        idle_d       = active ? (rx_valid_i ? '0 : idle_q + 32'd1) : '0;
        len_w        = {rx_data_i, n_q[7:0]};
        end_addr     = 64'(LOAD_BASE) + 64'(len_w) * 64'(BYTES);
        too_big      = (32'(len_w) > 32'(MAX_WORDS)) ||
                       (end_addr > (64'd1 << ADDR_WIDTH));

        // address moves on only after the write cycle has shown it
        if (mem_we_q) begin
            addr_d = addr_q + ADDR_WIDTH'(BYTES);
        end

        unique case (state_q)
            WAIT_MAGIC: begin
                if (rx_valid_i && (rx_data_i == BOOT_MAGIC)) begin
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                if (rx_valid_i) begin
                    n_d     = {8'h00, rx_data_i};
                    state_d = LEN_HI;
                end
            end
            LEN_HI: begin
                if (rx_valid_i) begin
                    n_d = len_w;
                    if (len_w == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (too_big) begin
                        state_d = ERROR;
                        error_d = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
                if (rx_valid_i) begin
                    sum_d = sum_q + rx_data_i;
                end
`endif
                if (pk_valid) begin
                    mem_we_d = 1'b1;
                    wdata_d  = pk_word;
                    words_d  = words_q + 1'b1;
                    if (words_q == n_q - 1'b1) begin
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
                        state_d = CSUM;
`else
                        state_d = DONE;
                        done_d  = 1'b1;
`endif
                    end
                end
            end
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
            CSUM: begin
                if (rx_valid_i) begin
                    if (8'(sum_q + rx_data_i) == 8'h00) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ERROR;
                        error_d = 1'b1;
                    end
                end
            end
`endif
            DONE: begin
                core_rst_n_d = 1'b1;
            end
            default: begin
            end
        endcase

        if (timeout) begin
            state_d = WAIT_MAGIC;
            n_d     = '0;
            words_d = '0;
            addr_d  = BASE;
            idle_d  = '0;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
            sum_d   = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= WAIT_MAGIC;
            n_q          <= '0;
            words_q      <= '0;
            addr_q       <= BASE;
            idle_q       <= '0;
            mem_we_q     <= 1'b0;
            wdata_q      <= '0;
            core_rst_n_q <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            words_q      <= words_d;
            addr_q       <= addr_d;
            idle_q       <= idle_d;
            mem_we_q     <= mem_we_d;
            wdata_q      <= wdata_d;
            core_rst_n_q <= core_rst_n_d;
            done_q       <= done_d;
            error_q      <= error_d;
`ifdef UART_BOOT_LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign core_rst_n_o = core_rst_n_q;
    assign done_o       = done_q;
    assign error_o      = error_q;

endmodule
